// File: rtl/timer_pkg.sv
// Shared constants for the timer block: flag bit positions and count direction.
package timer_pkg;
   localparam int FLAG_OVF  = 0;
   localparam int FLAG_UDF  = 1;
   localparam int FLAG_CMP  = 2;
   localparam int NUM_FLAGS = 3;

   localparam logic CNT_UP = 1'b0;
   localparam logic CNT_DN = 1'b1;
endpackage

// File: rtl/timer_tick_gen.sv
// Tick source for the timer: pclk prescaler or synchronised clk_in rising edge.
module timer_tick_gen #(
   parameter int DIV_W = 2
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             clk_in,
   input  logic             en,
   input  logic             load,
   input  logic             ext_sel,
   input  logic [DIV_W-1:0] div_sel,
   output logic             tick
);
   localparam int PRE_W = 2**DIV_W;

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_mask;
   logic             sync1, sync2, prev;
   logic             int_tick, ext_tick;

   // mask covers pre_cnt[div_sel:0]; tick when those bits are all ones
   always_comb begin
      pre_mask = '0;
      for (int i = 0; i < PRE_W; i++)
         pre_mask[i] = (i <= int'(div_sel));
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)
         pre_cnt <= '0;
      else if (!en || load || ext_sel)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + PRE_W'(1);
   end

   // edge history runs regardless of en so raising en never fires a stale edge
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= clk_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign int_tick = en && !ext_sel && ((pre_cnt & pre_mask) == pre_mask);
   assign ext_tick = ext_sel && sync2 && !prev;
   assign tick     = int_tick || ext_tick;
endmodule

// File: rtl/timer_core.sv
// Timer counter with load, up/down count, sticky event flags and maskable irq.
module timer_core
   import timer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 2
) (
   input  logic                 pclk,
   input  logic                 presetn,
   input  logic                 clk_in,
   input  logic                 en,
   input  logic                 ud,
   input  logic                 load,
   input  logic [WIDTH-1:0]     tdr,
   input  logic [WIDTH-1:0]     cmp,
   input  logic                 ext_sel,
   input  logic [DIV_W-1:0]     div_sel,
   input  logic [NUM_FLAGS-1:0] clr_trig,
   input  logic [NUM_FLAGS-1:0] ie,
   output logic [WIDTH-1:0]     cnt,
   output logic                 ovf_trig,
   output logic                 udf_trig,
   output logic                 cmp_trig,
   output logic                 irq
);
   logic                 tick;
   logic                 adv;
   logic [WIDTH-1:0]     cnt_q, cnt_nxt;
   logic [NUM_FLAGS-1:0] flags, flag_set;

   timer_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .pclk    (pclk),
      .presetn (presetn),
      .clk_in  (clk_in),
      .en      (en),
      .load    (load),
      .ext_sel (ext_sel),
      .div_sel (div_sel),
      .tick    (tick)
   );

   // load outranks a coincident tick, so it also suppresses that tick's events
   always_comb begin
      adv     = en && tick && !load;
      cnt_nxt = (ud == CNT_DN) ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
      flag_set           = '0;
      flag_set[FLAG_OVF] = adv && (ud == CNT_UP) && (&cnt_q);
      flag_set[FLAG_UDF] = adv && (ud == CNT_DN) && (cnt_q == '0);
      flag_set[FLAG_CMP] = adv && (cnt_nxt == cmp);
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cnt_q <= '0;
         flags <= '0;
      end else begin
         if (load)
            cnt_q <= tdr;
         else if (adv)
            cnt_q <= cnt_nxt;
         flags <= flag_set | (flags & ~clr_trig);
      end
   end

   assign cnt      = cnt_q;
   assign ovf_trig = flags[FLAG_OVF];
   assign udf_trig = flags[FLAG_UDF];
   assign cmp_trig = flags[FLAG_CMP];
   assign irq      = |(flags & ie);
endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: directed scenarios plus randomized run vs a cycle model.
module tb_timer_core;
   logic        pclk = 1'b0;
   logic        presetn;
   logic        clk_in, en, ud, load, ext_sel;
   logic [1:0]  div_sel;
   logic [7:0]  tdr, cmp, cnt;
   logic [15:0] tdr16, cmp16, cnt16;
   logic [2:0]  clr_trig, ie;
   logic        ovf, udf, cmpf, irq;
   logic        ovf16, udf16, cmpf16, irq16;

   int checks = 0;
   int errors = 0;

   always #5 pclk = ~pclk;

   timer_core #(.WIDTH(8), .DIV_W(2)) dut (
      .pclk(pclk), .presetn(presetn), .clk_in(clk_in), .en(en), .ud(ud), .load(load),
      .tdr(tdr), .cmp(cmp), .ext_sel(ext_sel), .div_sel(div_sel), .clr_trig(clr_trig),
      .ie(ie), .cnt(cnt), .ovf_trig(ovf), .udf_trig(udf), .cmp_trig(cmpf), .irq(irq)
   );

   timer_core #(.WIDTH(16), .DIV_W(2)) dut16 (
      .pclk(pclk), .presetn(presetn), .clk_in(clk_in), .en(en), .ud(ud), .load(load),
      .tdr(tdr16), .cmp(cmp16), .ext_sel(ext_sel), .div_sel(div_sel), .clr_trig(clr_trig),
      .ie(ie), .cnt(cnt16), .ovf_trig(ovf16), .udf_trig(udf16), .cmp_trig(cmpf16), .irq(irq16)
   );

   // Reference model: enabled-cycle phase counter, clk_in sample history, integer count.
   int         m_phase;
   logic [2:0] m_last;
   logic [7:0] m_cnt;
   logic [2:0] m_flags;

   always @(posedge pclk or negedge presetn) begin
      int   period, c;
      bit   t;
      logic [2:0] nf;
      if (!presetn) begin
         m_phase <= 0;
         m_last  <= '0;
         m_cnt   <= '0;
         m_flags <= '0;
      end else begin
         period = 2 << div_sel;
         t  = ext_sel ? (m_last[1] && !m_last[2]) : (en && ((m_phase + 1) % period == 0));
         nf = m_flags & ~clr_trig;
         c  = m_cnt;
         if (load) begin
            c = tdr;
         end else if (en && t) begin
            c = ud ? c - 1 : c + 1;
            if (c == 256) nf[0] = 1'b1;
            if (c == -1)  nf[1] = 1'b1;
            c = (c + 256) % 256;
            if (c == int'(cmp)) nf[2] = 1'b1;
         end
         m_cnt   <= 8'(c);
         m_flags <= nf;
         m_phase <= (!en || load || ext_sel) ? 0 : m_phase + 1;
         m_last  <= {m_last[1:0], clk_in};
      end
   end

   task automatic step();
      @(negedge pclk);
   endtask

   task automatic test_reset();
      presetn = 1'b0; clk_in = 0; en = 0; ud = 0; load = 0; ext_sel = 0; div_sel = 0;
      tdr = 0; cmp = 8'h80; tdr16 = 0; cmp16 = 16'h1234; clr_trig = 0; ie = 0;
      step(); step();
      checks++;
      if (cnt !== 8'h00 || {ovf, udf, cmpf, irq} !== 4'b0000) begin
         errors++; $display("FAIL reset_active: cnt=%0h flags/irq=%b expected 0/0000", cnt, {ovf, udf, cmpf, irq});
      end
      presetn = 1'b1;
      step();
      checks++;
      if (cnt !== 8'h00 || {ovf, udf, cmpf, irq} !== 4'b0000) begin
         errors++; $display("FAIL reset_release: cnt=%0h flags/irq=%b expected 0/0000", cnt, {ovf, udf, cmpf, irq});
      end
   endtask

   task automatic test_up_wrap();
      logic [7:0] exp_seq [5] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00};
      ext_sel = 0; div_sel = 0; ud = 0; tdr = 8'hFE; tdr16 = 16'hFFFF; load = 1; en = 1;
      step(); load = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (cnt !== exp_seq[i]) begin
            errors++; $display("FAIL up_wrap_cnt[%0d]: got %0h expected %0h", i, cnt, exp_seq[i]);
         end
         if (i == 2) begin
            checks++;
            if (cnt16 !== 16'h0000 || ovf16 !== 1'b1) begin
               errors++; $display("FAIL up_wrap16: cnt16=%0h ovf16=%b expected 0000/1", cnt16, ovf16);
            end
         end
         if (i == 3) begin
            checks++;
            if (ovf !== 1'b0) begin
               errors++; $display("FAIL up_wrap_early_ovf: got %b expected 0", ovf);
            end
         end
      end
      checks++;
      if (ovf !== 1'b1 || udf !== 1'b0) begin
         errors++; $display("FAIL up_wrap_flags: ovf=%b udf=%b expected 1/0", ovf, udf);
      end
      en = 0;
   endtask

   task automatic test_down_irq();
      logic [7:0] exp_seq [5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'hFF};
      clr_trig = 3'b111; en = 0; step(); clr_trig = 0;
      ie = 3'b010; ud = 1; tdr = 8'h01; load = 1; en = 1;
      step(); load = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         checks++;
         if (cnt !== exp_seq[i]) begin
            errors++; $display("FAIL down_cnt[%0d]: got %0h expected %0h", i, cnt, exp_seq[i]);
         end
      end
      checks++;
      if (udf !== 1'b1 || irq !== 1'b1 || ovf !== 1'b0) begin
         errors++; $display("FAIL down_flags: udf=%b irq=%b ovf=%b expected 1/1/0", udf, irq, ovf);
      end
      en = 0; clr_trig = 3'b010;
      step(); clr_trig = 0;
      checks++;
      if (udf !== 1'b0 || irq !== 1'b0) begin
         errors++; $display("FAIL down_clear: udf=%b irq=%b expected 0/0", udf, irq);
      end
   endtask

   task automatic test_ext_clk();
      ud = 0; ext_sel = 1; clk_in = 0; tdr = 8'h20; load = 1; en = 1;
      step(); load = 0; step(); step();
      for (int r = 0; r < 4; r++) begin
         clk_in = 1;
         step();
         step();
         checks++;
         if (cnt !== 8'(8'h20 + r)) begin
            errors++; $display("FAIL ext_early[%0d]: got %0h expected %0h", r, cnt, 8'(8'h20 + r));
         end
         step();
         checks++;
         if (cnt !== 8'(8'h21 + r)) begin
            errors++; $display("FAIL ext_edge[%0d]: got %0h expected %0h", r, cnt, 8'(8'h21 + r));
         end
         step(); step();
         clk_in = 0;
         repeat (5) step();
      end
      clk_in = 1;
      repeat (50) step();
      checks++;
      if (cnt !== 8'h25) begin
         errors++; $display("FAIL ext_hold: got %0h expected 25", cnt);
      end
      clk_in = 0; repeat (3) step();
      ext_sel = 0; en = 0;
   endtask

   task automatic test_collisions();
      clr_trig = 3'b111; en = 0; ext_sel = 0; div_sel = 0; ud = 0; cmp = 8'h80;
      step(); clr_trig = 0;
      tdr = 8'hFF; load = 1; en = 1; step(); load = 0; step();
      tdr = 8'h42; load = 1; step(); load = 0;
      checks++;
      if (cnt !== 8'h42 || ovf !== 1'b0) begin
         errors++; $display("FAIL load_vs_tick: cnt=%0h ovf=%b expected 42/0", cnt, ovf);
      end
      tdr = 8'hFF; load = 1; step(); load = 0; step(); step();
      checks++;
      if (cnt !== 8'h00 || ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_first: cnt=%0h ovf=%b expected 00/1", cnt, ovf);
      end
      load = 1; step(); load = 0; step();
      clr_trig = 3'b001; step(); clr_trig = 0;
      checks++;
      if (cnt !== 8'h00 || ovf !== 1'b1) begin
         errors++; $display("FAIL set_vs_clear: cnt=%0h ovf=%b expected 00/1", cnt, ovf);
      end
      en = 0; clr_trig = 3'b001; step(); clr_trig = 0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_clear: got %b expected 0", ovf);
      end
   endtask

   task automatic test_compare();
      clr_trig = 3'b111; step(); clr_trig = 0;
      cmp = 8'h10; tdr = 8'h0E; ud = 0; load = 1; en = 1;
      step(); load = 0; step(); step();
      checks++;
      if (cnt !== 8'h0F || cmpf !== 1'b0) begin
         errors++; $display("FAIL cmp_before: cnt=%0h cmp_trig=%b expected 0F/0", cnt, cmpf);
      end
      step(); step();
      checks++;
      if (cnt !== 8'h10 || cmpf !== 1'b1) begin
         errors++; $display("FAIL cmp_hit: cnt=%0h cmp_trig=%b expected 10/1", cnt, cmpf);
      end
      en = 0; clr_trig = 3'b100; step(); clr_trig = 0;
      tdr = 8'h10; load = 1; step(); load = 0;
      checks++;
      if (cnt !== 8'h10 || cmpf !== 1'b0) begin
         errors++; $display("FAIL cmp_load: cnt=%0h cmp_trig=%b expected 10/0", cnt, cmpf);
      end
   endtask

   task automatic test_reset_mid();
      ie = 3'b111; ud = 0; div_sel = 0; ext_sel = 0;
      tdr = 8'hFF; load = 1; en = 1; step(); load = 0; step(); step();
      tdr = 8'h36; load = 1; step(); load = 0; step(); step();
      en = 0;
      checks++;
      if (cnt !== 8'h37 || ovf !== 1'b1 || irq !== 1'b1) begin
         errors++; $display("FAIL pre_reset: cnt=%0h ovf=%b irq=%b expected 37/1/1", cnt, ovf, irq);
      end
      #2 presetn = 1'b0;
      #1;
      checks++;
      if (cnt !== 8'h00 || {ovf, udf, cmpf, irq} !== 4'b0000) begin
         errors++; $display("FAIL async_reset: cnt=%0h flags/irq=%b expected 00/0000", cnt, {ovf, udf, cmpf, irq});
      end
      en = 1;
      step(); presetn = 1'b1;
      step();
      checks++;
      if (cnt !== 8'h00) begin
         errors++; $display("FAIL post_reset_hold: got %0h expected 00", cnt);
      end
      step();
      checks++;
      if (cnt !== 8'h01 || {ovf, udf, cmpf} !== 3'b000) begin
         errors++; $display("FAIL post_reset_tick: cnt=%0h flags=%b expected 01/000", cnt, {ovf, udf, cmpf});
      end
      en = 0;
   endtask

   task automatic test_random();
      logic exp_irq;
      for (int i = 0; i < 800; i++) begin
         step();
         exp_irq = |(m_flags & ie);
         checks++;
         if (cnt !== m_cnt || {cmpf, udf, ovf} !== m_flags || irq !== exp_irq) begin
            errors++;
            $display("FAIL random[%0d]: cnt=%0h flags=%b irq=%b expected %0h/%b/%b",
                     i, cnt, {cmpf, udf, ovf}, irq, m_cnt, m_flags, exp_irq);
         end
         en       = ($urandom % 8) != 0;
         if ($urandom % 16 == 0) ud = ~ud;
         load     = ($urandom % 20) == 0;
         tdr      = ($urandom % 2) ? 8'($urandom) : ($urandom % 2 ? 8'hFF : 8'h00);
         if ($urandom % 32 == 0) cmp = 8'($urandom);
         if ($urandom % 40 == 0) ext_sel = ~ext_sel;
         if ($urandom % 30 == 0) div_sel = 2'($urandom);
         clr_trig = ($urandom % 6 == 0) ? 3'($urandom) : 3'b000;
         if ($urandom % 25 == 0) ie = 3'($urandom);
         if ($urandom % 3 == 0) clk_in = ~clk_in;
      end
      load = 0; en = 0; clr_trig = 0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_irq();
      test_ext_clk();
      test_collisions();
      test_compare();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
